// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control, adder-operand and fetch-address bundle for pc_sequencer
//
// Signal summary:
//   stall, branch_taken, branch_offset, jump, jump_target, halt, resume
//       control into the sequencer
//   add_a, add_b   operands to the external combinational adder
//   add_result     sum returned by that adder
//   pc, pc_valid   fetch address and its qualifier
//   state          00 RUN, 01 FLUSH, 10 HALTED
// The slave modport is the sequencer's view. The master modport is the
// view of whatever drives the control inputs and supplies the adder.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_offset;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_result;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic [1:0]       state;

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target,
               halt, resume, add_result,
        output add_a, add_b, pc, pc_valid, state
    );

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target,
               halt, resume, add_result,
        input  add_a, add_b, pc, pc_valid, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer feeding an external 16-bit adder
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pc_sequencer_if.slave, which carries:
//          control inputs (stall, branch, jump, halt, resume)
//          adder operands out (add_a, add_b) and sum in (add_result)
//          fetch address (pc, pc_valid) and state
// The PC advances by taking the adder sum in the same cycle. Jump targets are
// loaded directly and do not pass through the adder.
module pc_sequencer #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               INC      = 2
) (
    input  logic               clk,
    input  logic               rst,
    pc_sequencer_if.slave      bus
);
    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_FLUSH  = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_t           st;
    logic [WIDTH-1:0] pc_q;

    // add_b follows branch_taken in every state. When the sequencer is not
    // in RUN, the sum is simply not used.
    assign bus.add_a    = pc_q;
    assign bus.add_b    = bus.branch_taken ? bus.branch_offset : INC_W;
    assign bus.pc       = pc_q;
    assign bus.state    = st;
    assign bus.pc_valid = (st == S_RUN) && !bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            st   <= S_RUN;
        end else begin
            case (st)
                S_RUN: begin
                    if (bus.halt) begin
                        st <= S_HALTED;
                    end else if (bus.stall) begin
                        // Hold the PC. Any redirect requested this cycle is dropped.
                        st <= S_RUN;
                    end else if (bus.jump) begin
                        pc_q <= bus.jump_target;
                        st   <= S_FLUSH;
                    end else if (bus.branch_taken) begin
                        pc_q <= bus.add_result;
                        st   <= S_FLUSH;
                    end else begin
                        pc_q <= bus.add_result;
                    end
                end
                S_FLUSH: begin
                    // Bubble cycle. The redirected PC is held, then fetched in RUN.
                    st <= bus.halt ? S_HALTED : S_RUN;
                end
                S_HALTED: begin
                    if (!bus.halt && bus.resume) begin
                        st <= S_RUN;
                    end
                end
                default: begin
                    st <= S_RUN;
                end
            endcase
        end
    end
endmodule
